// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory/bridge (slave).
// One request/acknowledge transaction at a time; ack and rdata are valid in the same cycle.
interface mem_access_if;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_strb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_addr, bus_strb, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_addr, bus_strb, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage: runs one bus transaction per load/store, stalls the pipe
// until acknowledge, aligns load data, builds store strobes and flags address errors.
module mem_access (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                mem_wreg,
    input  logic [4:0]          mem_wraddr,
    input  logic [31:0]         mem_wrdata,
    input  logic [7:0]          mem_aluop,
    input  logic [31:0]         mem_ramaddr,
    input  logic [31:0]         mem_opr2,
    input  logic [31:0]         mem_excp,
    input  logic [31:0]         mem_pc,
    input  logic                mem_inslot,
    mem_access_if.master        bus,
    output logic                mem_stall,
    output logic                wb_wreg,
    output logic [4:0]          wb_wraddr,
    output logic [31:0]         wb_wrdata,
    output logic [31:0]         wb_excp,
    output logic [31:0]         wb_badvaddr,
    output logic [31:0]         wb_pc,
    output logic                wb_inslot
);

    localparam logic [7:0] ALU_LB  = 8'h10;
    localparam logic [7:0] ALU_LBU = 8'h11;
    localparam logic [7:0] ALU_LH  = 8'h12;
    localparam logic [7:0] ALU_LHU = 8'h13;
    localparam logic [7:0] ALU_LW  = 8'h14;
    localparam logic [7:0] ALU_SB  = 8'h18;
    localparam logic [7:0] ALU_SH  = 8'h19;
    localparam logic [7:0] ALU_SW  = 8'h1A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_rdata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misalign;
    logic        w_adel;
    logic        w_ades;
    logic        w_go;
    logic [31:0] w_load_data;
    logic [31:0] w_excp;

    function automatic logic [31:0] align_load(input logic [7:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (op)
            ALU_LB:  align_load = {{24{b[7]}}, b};
            ALU_LBU: align_load = {24'h0, b};
            ALU_LH:  align_load = {{16{h[15]}}, h};
            ALU_LHU: align_load = {16'h0, h};
            default: align_load = rd;
        endcase
    endfunction

    assign w_is_load  = (mem_aluop == ALU_LB) || (mem_aluop == ALU_LBU) || (mem_aluop == ALU_LH) ||
                        (mem_aluop == ALU_LHU) || (mem_aluop == ALU_LW);
    assign w_is_store = (mem_aluop == ALU_SB) || (mem_aluop == ALU_SH) || (mem_aluop == ALU_SW);
    assign w_is_half  = (mem_aluop == ALU_LH) || (mem_aluop == ALU_LHU) || (mem_aluop == ALU_SH);
    assign w_is_word  = (mem_aluop == ALU_LW) || (mem_aluop == ALU_SW);
    assign w_misalign = (w_is_half && mem_ramaddr[0]) || (w_is_word && (mem_ramaddr[1:0] != 2'b00));
    assign w_adel     = w_is_load && w_misalign;
    assign w_ades     = w_is_store && w_misalign;
    assign w_go       = (w_is_load || w_is_store) && (mem_excp == 32'h0) && !w_misalign && !flush;
    assign w_load_data = align_load(mem_aluop, mem_ramaddr[1:0], bus.bus_rdata);
    assign w_excp     = mem_excp | {22'h0, w_ades, w_adel, 8'h0};

    // bus_req is registered so an asynchronous reset drops it immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.bus_ack) begin
                        r_req <= 1'b0;
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DONE;
                            r_rdata <= w_load_data;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (bus.bus_ack) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_req = r_req;

    // Everything else is combinational from EX/MEM, held at zero while reset is asserted
    always_comb begin
        bus.bus_wr    = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_strb  = 4'h0;
        bus.bus_wdata = 32'h0;
        mem_stall     = 1'b0;
        wb_wreg       = 1'b0;
        wb_wraddr     = 5'h0;
        wb_wrdata     = 32'h0;
        wb_excp       = 32'h0;
        wb_badvaddr   = 32'h0;
        wb_pc         = 32'h0;
        wb_inslot     = 1'b0;
        if (rst) begin
            bus.bus_wr   = w_is_store;
            bus.bus_addr = {mem_ramaddr[31:2], 2'b00};
            case (mem_aluop)
                ALU_SB: begin
                    bus.bus_strb  = 4'b0001 << mem_ramaddr[1:0];
                    bus.bus_wdata = {4{mem_opr2[7:0]}};
                end
                ALU_SH: begin
                    bus.bus_strb  = 4'b0011 << {mem_ramaddr[1], 1'b0};
                    bus.bus_wdata = {2{mem_opr2[15:0]}};
                end
                ALU_SW: begin
                    bus.bus_strb  = 4'b1111;
                    bus.bus_wdata = mem_opr2;
                end
                default: begin
                    bus.bus_strb  = 4'h0;
                    bus.bus_wdata = mem_opr2;
                end
            endcase
            mem_stall   = ((r_state == S_IDLE) && w_go) || r_req;
            wb_wraddr   = mem_wraddr;
            wb_wrdata   = (w_is_load && (r_state == S_DONE)) ? r_rdata : mem_wrdata;
            wb_excp     = w_excp;
            wb_badvaddr = (w_excp[8] || w_excp[9]) ? mem_ramaddr : 32'h0;
            wb_wreg     = mem_wreg && !w_is_store && !(w_is_load && (r_state != S_DONE)) &&
                          (w_excp == 32'h0);
            wb_pc       = mem_pc;
            wb_inslot   = mem_inslot;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, address errors, flush/drain and async reset.
module tb_mem_access;

    localparam logic [7:0] ALU_ADD = 8'h01;
    localparam logic [7:0] ALU_LB  = 8'h10;
    localparam logic [7:0] ALU_LBU = 8'h11;
    localparam logic [7:0] ALU_LH  = 8'h12;
    localparam logic [7:0] ALU_LHU = 8'h13;
    localparam logic [7:0] ALU_LW  = 8'h14;
    localparam logic [7:0] ALU_SB  = 8'h18;
    localparam logic [7:0] ALU_SH  = 8'h19;
    localparam logic [7:0] ALU_SW  = 8'h1A;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_wreg;
    logic [4:0]  mem_wraddr;
    logic [31:0] mem_wrdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_ramaddr;
    logic [31:0] mem_opr2;
    logic [31:0] mem_excp;
    logic [31:0] mem_pc;
    logic        mem_inslot;
    logic        mem_stall;
    logic        wb_wreg;
    logic [4:0]  wb_wraddr;
    logic [31:0] wb_wrdata;
    logic [31:0] wb_excp;
    logic [31:0] wb_badvaddr;
    logic [31:0] wb_pc;
    logic        wb_inslot;

    int n_chk;
    int n_err;

    mem_access_if bus_if ();

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mem_wreg    (mem_wreg),
        .mem_wraddr  (mem_wraddr),
        .mem_wrdata  (mem_wrdata),
        .mem_aluop   (mem_aluop),
        .mem_ramaddr (mem_ramaddr),
        .mem_opr2    (mem_opr2),
        .mem_excp    (mem_excp),
        .mem_pc      (mem_pc),
        .mem_inslot  (mem_inslot),
        .bus         (bus_if.master),
        .mem_stall   (mem_stall),
        .wb_wreg     (wb_wreg),
        .wb_wraddr   (wb_wraddr),
        .wb_wrdata   (wb_wrdata),
        .wb_excp     (wb_excp),
        .wb_badvaddr (wb_badvaddr),
        .wb_pc       (wb_pc),
        .wb_inslot   (wb_inslot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_nop();
        mem_aluop   = ALU_ADD;
        mem_ramaddr = 32'h0;
        mem_opr2    = 32'h0;
        mem_wreg    = 1'b1;
        mem_wraddr  = 5'd9;
        mem_wrdata  = 32'h0000_1111;
        mem_excp    = 32'h0;
        flush       = 1'b0;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] opr2);
        mem_aluop   = op;
        mem_ramaddr = addr;
        mem_opr2    = opr2;
        mem_wreg    = 1'b1;
        mem_wraddr  = 5'd3;
        mem_wrdata  = 32'h5555_0000;
        mem_excp    = 32'h0;
        flush       = 1'b0;
    endtask

    // Called in an IDLE cycle; ack arrives after 'waits' extra WAIT cycles.
    task automatic run_access(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] opr2, input logic [31:0] rdata, input int waits,
                              input logic [31:0] exp_wd, input logic exp_wreg);
        set_op(op, addr, opr2);
        #1;
        chk({tag, " idle stall"}, {31'h0, mem_stall}, 32'h1);
        chk({tag, " idle req"}, {31'h0, bus_if.bus_req}, 32'h0);
        tick();
        chk({tag, " wait req"}, {31'h0, bus_if.bus_req}, 32'h1);
        chk({tag, " wait stall"}, {31'h0, mem_stall}, 32'h1);
        chk({tag, " wait wreg"}, {31'h0, wb_wreg}, 32'h0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({tag, " wait2 req"}, {31'h0, bus_if.bus_req}, 32'h1);
        end
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
        tick();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        #1;
        chk({tag, " done req"}, {31'h0, bus_if.bus_req}, 32'h0);
        chk({tag, " done stall"}, {31'h0, mem_stall}, 32'h0);
        chk({tag, " done wrdata"}, wb_wrdata, exp_wd);
        chk({tag, " done wreg"}, {31'h0, wb_wreg}, {31'h0, exp_wreg});
        tick();
        set_nop();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b0;
        mem_pc     = 32'hBFC0_0040;
        mem_inslot = 1'b1;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
        set_nop();
        mem_aluop   = ALU_LW;
        mem_wrdata  = 32'h0000_1234;
        #3;
        chk("rst req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("rst stall", {31'h0, mem_stall}, 32'h0);
        chk("rst wrdata", wb_wrdata, 32'h0);
        chk("rst wreg", {31'h0, wb_wreg}, 32'h0);
        chk("rst pc", wb_pc, 32'h0);
        chk("rst addr", bus_if.bus_addr, 32'h0);
        set_nop();
        #9 rst = 1'b1;
        tick();
        #1;
        chk("nop wrdata", wb_wrdata, 32'h0000_1111);
        chk("nop wreg", {31'h0, wb_wreg}, 32'h1);
        chk("nop wraddr", {27'h0, wb_wraddr}, 32'd9);
        chk("nop pc", wb_pc, 32'hBFC0_0040);
        chk("nop inslot", {31'h0, wb_inslot}, 32'h1);
        chk("nop stall", {31'h0, mem_stall}, 32'h0);

        run_access("lw100", ALU_LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b1);
        run_access("lb103", ALU_LB, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 32'hFFFF_FF80, 1'b1);
        run_access("lbu103", ALU_LBU, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 32'h0000_0080, 1'b1);
        run_access("lh102", ALU_LH, 32'h0000_0102, 32'h0, 32'h8011_2233, 0, 32'hFFFF_8011, 1'b1);
        run_access("lhu100", ALU_LHU, 32'h0000_0100, 32'h0, 32'h8011_A233, 0, 32'h0000_A233, 1'b1);
        run_access("lb101", ALU_LB, 32'h0000_0101, 32'h0, 32'h8011_2233, 2, 32'h0000_0022, 1'b1);

        set_op(ALU_SB, 32'h0000_0201, 32'h0000_00AB);
        #1;
        chk("sb strb", {28'h0, bus_if.bus_strb}, 32'h2);
        chk("sb wdata", bus_if.bus_wdata, 32'hABAB_ABAB);
        chk("sb wr", {31'h0, bus_if.bus_wr}, 32'h1);
        chk("sb addr", bus_if.bus_addr, 32'h0000_0200);
        run_access("sb201", ALU_SB, 32'h0000_0201, 32'h0000_00AB, 32'h0, 0, 32'h5555_0000, 1'b0);
        set_op(ALU_SH, 32'h0000_0202, 32'h1234_CDEF);
        #1;
        chk("sh strb", {28'h0, bus_if.bus_strb}, 32'hC);
        chk("sh wdata", bus_if.bus_wdata, 32'hCDEF_CDEF);
        set_op(ALU_SW, 32'h0000_0204, 32'h1234_CDEF);
        #1;
        chk("sw strb", {28'h0, bus_if.bus_strb}, 32'hF);
        chk("sw wdata", bus_if.bus_wdata, 32'h1234_CDEF);
        run_access("sw204", ALU_SW, 32'h0000_0204, 32'h1234_CDEF, 32'h0, 0, 32'h5555_0000, 1'b0);

        set_op(ALU_LW, 32'h0000_0102, 32'h0);
        #1;
        chk("adel stall", {31'h0, mem_stall}, 32'h0);
        chk("adel excp", wb_excp, 32'h0000_0100);
        chk("adel badv", wb_badvaddr, 32'h0000_0102);
        chk("adel wreg", {31'h0, wb_wreg}, 32'h0);
        tick();
        chk("adel req", {31'h0, bus_if.bus_req}, 32'h0);
        set_op(ALU_SH, 32'h0000_0301, 32'h0);
        #1;
        chk("ades excp", wb_excp, 32'h0000_0200);
        chk("ades badv", wb_badvaddr, 32'h0000_0301);
        chk("ades stall", {31'h0, mem_stall}, 32'h0);
        set_op(ALU_LW, 32'h0000_0104, 32'h0);
        mem_excp = 32'h0000_0010;
        #1;
        chk("excp stall", {31'h0, mem_stall}, 32'h0);
        chk("excp badv", wb_badvaddr, 32'h0);
        tick();
        chk("excp req", {31'h0, bus_if.bus_req}, 32'h0);

        set_op(ALU_LW, 32'h0000_0104, 32'h0);
        flush = 1'b1;
        #1;
        chk("idleflush stall", {31'h0, mem_stall}, 32'h0);
        tick();
        chk("idleflush req", {31'h0, bus_if.bus_req}, 32'h0);

        set_op(ALU_LW, 32'h0000_0104, 32'h0);
        tick();
        flush = 1'b1;
        #1;
        chk("flush wait req", {31'h0, bus_if.bus_req}, 32'h1);
        tick();
        flush = 1'b0;
        #1;
        chk("drain1 req", {31'h0, bus_if.bus_req}, 32'h1);
        chk("drain1 stall", {31'h0, mem_stall}, 32'h1);
        chk("drain1 wreg", {31'h0, wb_wreg}, 32'h0);
        tick();
        chk("drain2 req", {31'h0, bus_if.bus_req}, 32'h1);
        tick();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h7777_7777;
        #1;
        chk("drain3 stall", {31'h0, mem_stall}, 32'h1);
        tick();
        bus_if.bus_ack = 1'b0;
        #1;
        chk("postdrain req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("postdrain wreg", {31'h0, wb_wreg}, 32'h0);
        chk("postdrain wrdata", wb_wrdata, 32'h5555_0000);
        set_nop();

        tick();
        set_op(ALU_LW, 32'h0000_0108, 32'h0);
        tick();
        flush            = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_5678;
        tick();
        flush          = 1'b0;
        bus_if.bus_ack = 1'b0;
        #1;
        chk("flushack req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("flushack wreg", {31'h0, wb_wreg}, 32'h0);
        chk("flushack stall", {31'h0, mem_stall}, 32'h1);
        set_nop();

        tick();
        set_op(ALU_LW, 32'h0000_010C, 32'h0);
        tick();
        chk("rstwait req", {31'h0, bus_if.bus_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("asyncrst req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("asyncrst stall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        set_nop();
        mem_wrdata = 32'hCAFE_0001;
        mem_wraddr = 5'd7;
        #1;
        chk("postrst wrdata", wb_wrdata, 32'hCAFE_0001);
        chk("postrst wraddr", {27'h0, wb_wraddr}, 32'd7);
        chk("postrst wreg", {31'h0, wb_wreg}, 32'h1);
        tick();
        chk("postrst req", {31'h0, bus_if.bus_req}, 32'h0);
        chk("postrst stall", {31'h0, mem_stall}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the MEM/WB register. It takes load/store operations from the EX/MEM register and runs one request/acknowledge transaction per access on the data bus. Its FSM stalls the pipeline until the bus answers. It also aligns and sign-extends load data, generates byte strobes for stores, and flags misaligned addresses as address-error exceptions.

## Interface
No parameters; widths come from the shared defines (`DataBus`/`AddrBus` 32, `RegAddr` 5, `AluOp`).
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- flush  in  1  pipeline flush from exception control
- mem_wreg / mem_wraddr / mem_wrdata  in  1/5/32  register write-back from EX/MEM
- mem_aluop  in  `AluOp`  operation; loads/stores are `ALU_LB/LBU/LH/LHU/LW/SB/SH/SW`
- mem_ramaddr  in  32  effective address
- mem_opr2  in  32  store data (rt)
- mem_excp  in  32  incoming exception vector
- mem_pc  in  32  PC of the instruction
- mem_inslot  in  1  instruction is in a delay slot
- bus_req  out  1  data-bus request
- bus_wr  out  1  1 = write
- bus_addr  out  32  word-aligned address {ramaddr[31:2],2'b00}
- bus_strb  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  one-cycle acknowledge; bus_rdata is valid in the same cycle
- bus_rdata  in  32  read data
- mem_stall  out  1  freeze IF..EX/MEM
- wb_wreg / wb_wraddr / wb_wrdata  out  1/5/32  to MEM/WB
- wb_excp  out  32  mem_excp plus bit 8 (AdEL) and bit 9 (AdES)
- wb_badvaddr  out  32  faulting address (mem_ramaddr when bit 8 or 9 is set, else 0)
- wb_pc / wb_inslot  out  32/1  pass-through

## Operation
- Misalignment rules:
  - Halfword access with addr[0]=1 is misaligned.
  - Word access with addr[1:0]≠0 is misaligned.
  - Load sets wb_excp[8]; store sets wb_excp[9].
  - A misaligned access issues no bus request and causes no stall; wb_wreg is forced to 0.
- Access is qualified as `go` = load/store op AND mem_excp==0 AND no misalignment AND flush==0.
- FSM states:
  - IDLE: mem_stall = go. If go: go to WAIT.
  - WAIT: bus_req=1, mem_stall=1.
    - bus_ack=1: latch aligned load data into rdata_q, go to DONE.
    - flush=1 with no ack: go to DRAIN.
    - flush and ack in the same cycle: go to IDLE.
  - DONE: bus_req=0, mem_stall=0, go to IDLE. The EX/MEM register advances at this edge, so the same op is not reissued.
  - DRAIN: bus_req=1, mem_stall=1, result discarded. bus_ack=1: go to IDLE.
- bus_wr, bus_addr, bus_strb and bus_wdata are driven from the EX/MEM inputs, which stay stable because of the stall.
- Store strobes and data:
  - SB: strb=0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: strb=0011<<{addr[1],1'b0}; wdata = halfword replicated ×2.
  - SW: strb=1111; wdata = opr2.
- Load lane selection:
  - Byte: lane addr[1:0].
  - Halfword: lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- wb_wrdata:
  - Load in DONE: rdata_q.
  - Otherwise: mem_wrdata.
  - Non-memory ops pass through unchanged, combinationally.
- wb_wreg: 0 for loads outside DONE, and 0 whenever wb_excp≠0. Otherwise mem_wreg.
- A store writes no register.

## Timing
- Reset (rst=0): state IDLE, rdata_q=0. All outputs are 0, including mem_stall, bus_req and every wb_* output.
- Load/store with ack in the first WAIT cycle takes 3 cycles in the stage: IDLE(stall) → WAIT(stall, ack) → DONE(no stall).
- Each extra cycle of bus wait adds 1 stall cycle.
- bus_req rises the cycle after the op is presented. It is held until the ack cycle inclusive and drops the cycle after.
- At most one outstanding transaction exists; a new one is never started from DRAIN.
- rst asserted mid-WAIT: state returns to IDLE immediately and bus_req drops asynchronously. The bus is expected to be reset with the core.
- Flush in IDLE with a memory op present: no request is issued.
- Back-to-back loads: after DONE, the next op enters IDLE with no bubble beyond the FSM sequence.

## Test plan
- LW addr 0x100, ack in 2nd WAIT cycle, rdata 0xDEADBEEF → bus_req high 2 cycles, mem_stall high 3 cycles, then wb_wrdata=0xDEADBEEF with wb_wreg=1 in DONE.
- LB addr 0x103, rdata 0x80112233 → wb_wrdata 0xFFFFFF80. LBU at the same address → 0x00000080. LH addr 0x102 → 0xFFFF8011.
- SB addr 0x201, opr2 0x000000AB → bus_strb 0010, bus_wdata 0xABABABAB, bus_wr=1, wb_wreg=0.
- LW addr 0x102 → no bus_req, mem_stall=0, wb_excp[8]=1, wb_badvaddr=0x102, wb_wreg=0. SH addr 0x301 → wb_excp[9]=1.
- Flush in the first WAIT cycle, ack 3 cycles later → DRAIN holds bus_req and mem_stall until the ack, then IDLE with no register write.
- rst low during WAIT → bus_req and mem_stall fall to 0 immediately. After release, an idle ADD op passes mem_wrdata unchanged.
